instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 270 +++++++++++++++++++++++++++
 tb/tb_instr_decode.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// RV32I decode stage: combinational field/immediate decode of the fetched
// word, registered into a single-entry bundle with a valid/ready handshake.
module instr_decode #(
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [3:0]  dec_op,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [31:0] dec_imm,
    output logic        dec_rd_we,
    output logic        dec_rs1_used,
    output logic        dec_rs2_used,
    output logic        dec_illegal,
    output logic        overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [3:0] OP_LUI    = 4'd0;
    localparam logic [3:0] OP_AUIPC  = 4'd1;
    localparam logic [3:0] OP_JAL    = 4'd2;
    localparam logic [3:0] OP_JALR   = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LOAD   = 4'd5;
    localparam logic [3:0] OP_STORE  = 4'd6;
    localparam logic [3:0] OP_OPIMM  = 4'd7;
    localparam logic [3:0] OP_OP     = 4'd8;
    localparam logic [3:0] OP_FENCE  = 4'd9;
    localparam logic [3:0] OP_SYSTEM = 4'd10;
    localparam logic [3:0] OP_ILL    = 4'd15;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rd  = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    logic [3:0]  op_c;
    logic [31:0] imm_c;
    logic        bad_c;

    // bad_c collects the funct3/funct7 encodings RV32I leaves reserved
    always_comb begin
        op_c  = OP_ILL;
        imm_c = 32'h0;
        bad_c = 1'b0;
        unique case (opc)
            OPC_LUI: begin
                op_c  = OP_LUI;
                imm_c = imm_u;
            end
            OPC_AUIPC: begin
                op_c  = OP_AUIPC;
                imm_c = imm_u;
            end
            OPC_JAL: begin
                op_c  = OP_JAL;
                imm_c = imm_j;
            end
            OPC_JALR: begin
                op_c  = OP_JALR;
                imm_c = imm_i;
                bad_c = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                op_c  = OP_BRANCH;
                imm_c = imm_b;
                bad_c = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                op_c  = OP_LOAD;
                imm_c = imm_i;
                bad_c = (f3 == 3'b011) || (f3 == 3'b110) ||
                        (f3 == 3'b111);
            end
            OPC_STORE: begin
                op_c  = OP_STORE;
                imm_c = imm_s;
                bad_c = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                op_c  = OP_OPIMM;
                imm_c = imm_i;
                bad_c = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                        ((f3 == 3'b101) && (f7 != 7'h00) &&
                         (f7 != 7'h20));
            end
            OPC_OP: begin
                op_c  = OP_OP;
                bad_c = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                        ((f7 == 7'h20) && (f3 != 3'b000) &&
                         (f3 != 3'b101));
            end
            OPC_FENCE:  op_c = OP_FENCE;
            OPC_SYSTEM: op_c = OP_SYSTEM;
            default: ;
        endcase
    end

    logic        ill_c;
    logic [3:0]  op_f;
    logic [31:0] imm_f;
    logic        rd_we_c;
    logic        rs1u_c;
    logic        rs2u_c;

    assign ill_c = (instr[1:0] != 2'b11) || (op_c == OP_ILL) ||
                   (CHECK_ILLEGAL && bad_c);
    assign op_f  = ill_c ? OP_ILL : op_c;
    assign imm_f = ill_c ? 32'h0 : imm_c;

    always_comb begin
        rd_we_c = 1'b0;
        rs1u_c  = 1'b0;
        rs2u_c  = 1'b0;
        unique case (op_f)
            OP_LUI, OP_AUIPC, OP_JAL: rd_we_c = 1'b1;
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                rd_we_c = 1'b1;
                rs1u_c  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                rs1u_c = 1'b1;
                rs2u_c = 1'b1;
            end
            OP_OP: begin
                rd_we_c = 1'b1;
                rs1u_c  = 1'b1;
                rs2u_c  = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) begin
            rd_we_c = 1'b0;
        end
    end

    state_e state_q;
    state_e state_d;
    logic   ovr_q;
    logic   ovr_d;
    logic   capture;

    // flush wins over everything; a stalled FULL entry drops new words
    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        capture = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (instr_valid) begin
                        capture = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (dec_ready) begin
                        capture = instr_valid;
                        state_d = instr_valid ? FULL : EMPTY;
                    end else if (instr_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [3:0]  op_q;
    logic [31:0] imm_q;
    logic        rd_we_q;
    logic        rs1u_q;
    logic        rs2u_q;
    logic        ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ovr_q   <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
            op_q    <= 4'd0;
            imm_q   <= 32'h0;
            rd_we_q <= 1'b0;
            rs1u_q  <= 1'b0;
            rs2u_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            if (capture) begin
                pc_q    <= pc;
                instr_q <= instr;
                op_q    <= op_f;
                imm_q   <= imm_f;
                rd_we_q <= rd_we_c;
                rs1u_q  <= rs1u_c;
                rs2u_q  <= rs2u_c;
                ill_q   <= ill_c;
            end
        end
    end

    assign dec_valid    = (state_q == FULL);
    assign dec_pc       = pc_q;
    assign dec_instr    = instr_q;
    assign dec_op       = op_q;
    assign dec_rd       = instr_q[11:7];
    assign dec_rs1      = instr_q[19:15];
    assign dec_rs2      = instr_q[24:20];
    assign dec_funct3   = instr_q[14:12];
    assign dec_funct7   = instr_q[31:25];
    assign dec_imm      = imm_q;
    assign dec_rd_we    = rd_we_q;
    assign dec_rs1_used = rs1u_q;
    assign dec_rs2_used = rs2u_q;
    assign dec_illegal  = ill_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed vector table, handshake corner cases,
// and random traffic against a transaction-level reference model.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        instr_valid = 1'b0;
    logic        flush = 1'b0;
    logic        dec_ready = 1'b0;

    logic        va, oa, vb, ob;
    logic [31:0] pca, insa, imma, pcb, insb, immb;
    logic [3:0]  opa, opb;
    logic [4:0]  rda, s1a, s2a, rdb, s1b, s2b;
    logic [2:0]  f3a, f3b;
    logic [6:0]  f7a, f7b;
    logic        wea, u1a, u2a, ila, web, u1b, u2b, ilb;

    always #5 clk = ~clk;

    instr_decode u_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc),
        .instr_valid(instr_valid), .flush(flush), .dec_ready(dec_ready),
        .dec_valid(va), .dec_pc(pca), .dec_instr(insa), .dec_op(opa),
        .dec_rd(rda), .dec_rs1(s1a), .dec_rs2(s2a), .dec_funct3(f3a),
        .dec_funct7(f7a), .dec_imm(imma), .dec_rd_we(wea),
        .dec_rs1_used(u1a), .dec_rs2_used(u2a), .dec_illegal(ila),
        .overrun(oa)
    );

    instr_decode #(.CHECK_ILLEGAL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc),
        .instr_valid(instr_valid), .flush(flush), .dec_ready(dec_ready),
        .dec_valid(vb), .dec_pc(pcb), .dec_instr(insb), .dec_op(opb),
        .dec_rd(rdb), .dec_rs1(s1b), .dec_rs2(s2b), .dec_funct3(f3b),
        .dec_funct7(f7b), .dec_imm(immb), .dec_rd_we(web),
        .dec_rs1_used(u1b), .dec_rs2_used(u2b), .dec_illegal(ilb),
        .overrun(ob)
    );

    logic [128:0] bun_a, bun_b;
    assign bun_a = {pca, insa, opa, rda, s1a, s2a, f3a, f7a, imma,
                    wea, u1a, u2a, ila};
    assign bun_b = {pcb, insb, opb, rdb, s1b, s2b, f3b, f7b, immb,
                    web, u1b, u2b, ilb};

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'h37: return 0;
            7'h17: return 1;
            7'h6F: return 2;
            7'h67: return 3;
            7'h63: return 4;
            7'h03: return 5;
            7'h23: return 6;
            7'h13: return 7;
            7'h33: return 8;
            7'h0F: return 9;
            7'h73: return 10;
            default: return 15;
        endcase
    endfunction

    function automatic logic [128:0] ref_bundle(input logic [31:0] w,
                                                input logic [31:0] p,
                                                input bit full);
        int cls, f3, f7, v;
        logic [31:0] imm;
        bit ill, we, u1, u2;
        cls = cls_of(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ill = (w[1:0] != 2'b11) || (cls == 15);
        if (full) begin
            if (cls == 3 && f3 != 0) ill = 1;
            if (cls == 4 && (f3 == 2 || f3 == 3)) ill = 1;
            if (cls == 5 && (f3 == 3 || f3 == 6 || f3 == 7)) ill = 1;
            if (cls == 6 && f3 > 2) ill = 1;
            if (cls == 8 && f7 != 0 && f7 != 32) ill = 1;
            if (cls == 8 && f7 == 32 && f3 != 0 && f3 != 5) ill = 1;
            if (cls == 7 && f3 == 1 && f7 != 0) ill = 1;
            if (cls == 7 && f3 == 5 && f7 != 0 && f7 != 32) ill = 1;
        end
        imm = 32'h0;
        case (cls)
            0, 1: imm = w & 32'hFFFF_F000;
            2: begin
                v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                imm = 32'(v - (w[31] ? (1 << 21) : 0));
            end
            3, 5, 7: begin
                v = int'(w[31:20]);
                imm = 32'(v - (w[31] ? 4096 : 0));
            end
            4: begin
                v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
                imm = 32'(v - (w[31] ? 8192 : 0));
            end
            6: begin
                v = int'({w[31:25], w[11:7]});
                imm = 32'(v - (w[31] ? 4096 : 0));
            end
            default: imm = 32'h0;
        endcase
        if (ill) begin
            cls = 15;
            imm = 32'h0;
        end
        u1 = cls inside {3, 4, 5, 6, 7, 8};
        u2 = cls inside {4, 6, 8};
        we = (cls inside {0, 1, 2, 3, 5, 7, 8}) && (w[11:7] != 5'd0);
        return {p, w, 4'(cls), w[11:7], w[19:15], w[24:20], w[14:12],
                w[31:25], imm, we, u1, u2, ill};
    endfunction

    bit          m_valid = 0;
    bit          m_ovr = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] m_ins = 0;

    task automatic model_edge();
        if (flush) m_valid = 0;
        else if (instr_valid && (!m_valid || dec_ready)) begin
            m_valid = 1;
            m_pc = pc;
            m_ins = instr;
        end else if (m_valid && dec_ready) m_valid = 0;
        else if (m_valid && instr_valid) m_ovr = 1;
    endtask

    task automatic cmp_model();
        chk("a_valid_ovr", {va, oa}, {m_valid, m_ovr});
        chk("b_valid_ovr", {vb, ob}, {m_valid, m_ovr});
        if (m_valid) begin
            chk("a_bundle", bun_a, ref_bundle(m_ins, m_pc, 1));
            chk("b_bundle", bun_b, ref_bundle(m_ins, m_pc, 0));
        end
    endtask

    task automatic step(input bit iv, input bit fl, input bit rdy,
                        input logic [31:0] w, input logic [31:0] p);
        instr_valid = iv;
        flush = fl;
        dec_ready = rdy;
        instr = w;
        pc = p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        m_valid = 0;
        m_ovr = 0;
        chk("rst_a", {va, oa, bun_a}, '0);
        chk("rst_b", {vb, ob, bun_b}, '0);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
        logic [3:0]  op1;
        logic [3:0]  op0;
        logic [31:0] imm;
        logic [3:0]  flags;
    } vec_t;

    vec_t tbl[10];
    logic [6:0] opcs[11];

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int s;
        w = $urandom;
        s = $urandom_range(0, 13);
        if (s < 11) w[6:0] = opcs[s];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // flags = {rd_we, rs1_used, rs2_used, illegal}
        tbl[0] = '{32'h0050_0093, 32'h0,   4'd7,  4'd7, 32'h5,        4'b1100};
        tbl[1] = '{32'h1234_5137, 32'h4,   4'd0,  4'd0, 32'h1234_5000, 4'b1000};
        tbl[2] = '{32'hFE00_0EE3, 32'h100, 4'd4,  4'd4, 32'hFFFF_FFFC, 4'b0110};
        tbl[3] = '{32'h0000_0000, 32'h8,   4'd15, 4'd15, 32'h0,       4'b0001};
        tbl[4] = '{32'h4000_F0B3, 32'hC,   4'd15, 4'd8, 32'h0,        4'b0001};
        tbl[5] = '{32'h0011_2623, 32'h10,  4'd6,  4'd6, 32'd12,       4'b0110};
        tbl[6] = '{32'h0080_00EF, 32'h14,  4'd2,  4'd2, 32'd8,        4'b1000};
        tbl[7] = '{32'h0000_0073, 32'h18,  4'd10, 4'd10, 32'h0,       4'b0000};
        tbl[8] = '{32'h0000_B083, 32'h1C,  4'd15, 4'd5, 32'h0,        4'b0001};
        tbl[9] = '{32'h0000_0013, 32'h20,  4'd7,  4'd7, 32'h0,        4'b0100};
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                 7'h13, 7'h33, 7'h0F, 7'h73};

        #2;
        chk("rst_a", {va, oa, bun_a}, '0);
        chk("rst_b", {vb, ob, bun_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 32'h0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, tbl[i].w, tbl[i].p);
            chk("tbl_a", {va, pca, opa, imma, wea, u1a, u2a, ila},
                {1'b1, tbl[i].p, tbl[i].op1, tbl[i].imm, tbl[i].flags});
            chk("tbl_b_op", {vb, opb}, {1'b1, tbl[i].op0});
            step(0, 0, 1, 32'h0, 32'h0);
            chk("tbl_drain", {va, vb}, 2'b00);
        end

        step(1, 0, 0, 32'h0050_0093, 32'h40);
        for (int i = 0; i < 5; i++) step(0, 0, 0, $urandom, $urandom);
        chk("bp_hold", {va, insa, pca, oa}, {1'b1, 32'h0050_0093, 32'h40, 1'b0});
        step(1, 0, 0, 32'h1234_5137, 32'h44);
        chk("bp_ovr", {va, insa, pca, oa}, {1'b1, 32'h0050_0093, 32'h40, 1'b1});
        step(1, 0, 1, 32'h1234_5137, 32'h48);
        chk("bp_new", {va, insa, pca, opa}, {1'b1, 32'h1234_5137, 32'h48, 4'd0});

        step(0, 1, 0, 32'h0, 32'h0);
        chk("flush", {va, oa}, 2'b01);
        step(1, 1, 1, 32'h0050_0093, 32'h50);
        chk("flush_iv", {va, oa}, 2'b01);

        step(1, 0, 0, 32'hFE00_0EE3, 32'h100);
        chk("pre_rst", va, 1'b1);
        do_reset();
        step(0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0050_0093, 32'h60);
        chk("post_rst", {va, oa, pca}, {1'b1, 1'b0, 32'h60});

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) < 3, rand_word(), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
